// File: rtl/frame_rd_logic_pkg.sv
// Shared definitions for the frame-buffer read mover: FSM states, MCB read
// instruction codes, burst sizing and per-density address widths.
package frame_rd_logic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CMD  = 2'd2,
        S_RD   = 2'd3
    } state_e;

    localparam logic [2:0] INSTR_RD     = 3'b001;
    localparam logic [2:0] INSTR_RD_PRE = 3'b011;

    localparam int BURST_MAX       = 64;
    localparam int WORDS_W         = 23;
    localparam int RD_ADDR_W       = 17;
    localparam int RD_ADDR_W_1GB   = 17;
    localparam int RD_ADDR_W_512MB = 16;

    // Words in the next burst: a full 64-word burst, or whatever is left.
    function automatic logic [6:0] burst_size(input logic [WORDS_W-1:0] words_left);
        return (words_left >= WORDS_W'(BURST_MAX)) ? 7'd64 : words_left[6:0];
    endfunction

endpackage

// File: rtl/frame_rd_logic_if.sv
// MCB port 3 read command/data channel plus the back FIFO write channel.
// master = read mover, slave = MCB port and back FIFO.
interface frame_rd_logic_if;

    logic        o_p3_cmd_en;
    logic [2:0]  ov_p3_cmd_instr;
    logic [5:0]  ov_p3_cmd_bl;
    logic [29:0] ov_p3_cmd_byte_addr;
    logic        i_p3_cmd_full;
    logic        o_p3_rd_en;
    logic [31:0] iv_p3_rd_data;
    logic        i_p3_rd_empty;
    logic [31:0] ov_buf_din;
    logic        o_buf_wr_en;
    logic        i_buf_pf;
    logic        i_buf_full;

    modport master (
        output o_p3_cmd_en, ov_p3_cmd_instr, ov_p3_cmd_bl, ov_p3_cmd_byte_addr,
        output o_p3_rd_en, ov_buf_din, o_buf_wr_en,
        input  i_p3_cmd_full, iv_p3_rd_data, i_p3_rd_empty, i_buf_pf, i_buf_full
    );

    modport slave (
        input  o_p3_cmd_en, ov_p3_cmd_instr, ov_p3_cmd_bl, ov_p3_cmd_byte_addr,
        input  o_p3_rd_en, ov_buf_din, o_buf_wr_en,
        output i_p3_cmd_full, iv_p3_rd_data, i_p3_rd_empty, i_buf_pf, i_buf_full
    );

endinterface

// File: rtl/frame_rd_cmd_gen.sv
// Read command generator: burst length, byte address, burst index and
// remaining-word bookkeeping for one frame.
module frame_rd_cmd_gen
    import frame_rd_logic_pkg::*;
#(
    parameter string RD_WR_WITH_PRE   = "FALSE",
    parameter string DDR3_MEM_DENSITY = "1Gb"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WORDS_W-1:0]   frame_words,
    input  logic                 issue,
    input  logic [1:0]           ptr,
    output logic [5:0]           bl,
    output logic [29:0]          byte_addr,
    output logic [2:0]           instr,
    output logic [RD_ADDR_W-1:0] rd_addr,
    output logic [WORDS_W-1:0]   words_left,
    output logic [6:0]           burst_words
);

    localparam bit         IS_512MB   = (DDR3_MEM_DENSITY == "512Mb");
    localparam logic [2:0] INSTR_CODE = (RD_WR_WITH_PRE == "TRUE") ? INSTR_RD_PRE : INSTR_RD;

    logic [RD_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WORDS_W-1:0]   words_left_q, words_left_d;
    logic [5:0]           bl_q, bl_d;
    logic [29:0]          byte_addr_q, byte_addr_d;
    logic [2:0]           instr_q, instr_d;
    logic [6:0]           burst_words_q, burst_words_d;
    logic [6:0]           next_words;
    logic [29:0]          next_addr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        next_words = burst_size(words_left_q);
        if (IS_512MB) next_addr = {4'b0, ptr, rd_addr_q[RD_ADDR_W_512MB-1:0], 8'b0};
        else          next_addr = {3'b0, ptr, rd_addr_q[RD_ADDR_W_1GB-1:0], 8'b0};

        rd_addr_d     = rd_addr_q;
        words_left_d  = words_left_q;
        bl_d          = bl_q;
        byte_addr_d   = byte_addr_q;
        instr_d       = instr_q;
        burst_words_d = burst_words_q;
        if (load) begin
            rd_addr_d    = '0;
            words_left_d = frame_words;
        end else if (issue) begin
            bl_d          = 6'(next_words - 7'd1);
            byte_addr_d   = next_addr;
            instr_d       = INSTR_CODE;
            burst_words_d = next_words;
            rd_addr_d     = rd_addr_q + RD_ADDR_W'(1);
            words_left_d  = words_left_q - WORDS_W'(next_words);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q     <= '0;
            words_left_q  <= '0;
            bl_q          <= '0;
            byte_addr_q   <= '0;
            instr_q       <= '0;
            burst_words_q <= '0;
        end else begin
            rd_addr_q     <= rd_addr_d;
            words_left_q  <= words_left_d;
            bl_q          <= bl_d;
            byte_addr_q   <= byte_addr_d;
            instr_q       <= instr_d;
            burst_words_q <= burst_words_d;
        end
    end

    assign bl          = bl_q;
    assign byte_addr   = byte_addr_q;
    assign instr       = instr_q;
    assign rd_addr     = rd_addr_q;
    assign words_left  = words_left_q;
    assign burst_words = burst_words_q;

endmodule

// File: rtl/frame_rd_logic.sv
// Read side of the DDR3 frame buffer: waits for a completed frame, arbitrates
// through the judge and streams the frame from MCB port 3 into the back FIFO.
module frame_rd_logic
    import frame_rd_logic_pkg::*;
#(
    parameter string RD_WR_WITH_PRE   = "FALSE",
    parameter string DDR3_MEM_DENSITY = "1Gb"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           iv_frame_depth,
    input  logic                 i_frame_en,
    input  logic [WORDS_W-1:0]   iv_frame_words,
    input  logic [1:0]           iv_wr_frame_ptr,
    input  logic                 i_writing,
    output logic                 o_rd_req,
    input  logic                 i_rd_ack,
    output logic [1:0]           ov_rd_frame_ptr,
    output logic                 o_reading,
    output logic [RD_ADDR_W-1:0] ov_rd_addr,
    input  logic                 i_calib_done,
    frame_rd_logic_if.master     bus
);

    state_e       state_q, state_d;
    logic         calib_meta_q, calib_sync_q;
    logic         writing_q;
    logic         frame_avail_q, frame_avail_d;
    logic [1:0]   last_done_ptr_q, last_done_ptr_d;
    logic [2:0]   depth_q, depth_d;
    logic         rd_req_q, rd_req_d;
    logic         reading_q, reading_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic         cmd_en_q, cmd_en_d;
    logic [6:0]   burst_cnt_q, burst_cnt_d;

    logic               wr_fall, able_to_read, ack_ok, issue, pop, last_pop, drained;
    logic [WORDS_W-1:0] words_left;
    logic [6:0]         burst_words;

    frame_rd_cmd_gen #(
        .RD_WR_WITH_PRE   (RD_WR_WITH_PRE),
        .DDR3_MEM_DENSITY (DDR3_MEM_DENSITY)
    ) u_cmd_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (ack_ok),
        .frame_words (iv_frame_words),
        .issue       (issue),
        .ptr         (rd_ptr_q),
        .bl          (bus.ov_p3_cmd_bl),
        .byte_addr   (bus.ov_p3_cmd_byte_addr),
        .instr       (bus.ov_p3_cmd_instr),
        .rd_addr     (ov_rd_addr),
        .words_left  (words_left),
        .burst_words (burst_words)
    );

    always_comb begin
        wr_fall = writing_q && !i_writing;
        unique case (depth_q)
            3'b001:         able_to_read = frame_avail_q && !i_writing;
            3'b010, 3'b100: able_to_read = frame_avail_q;
            default:        able_to_read = 1'b0;
        endcase
        ack_ok   = (state_q == S_REQ) && i_rd_ack && able_to_read;
        issue    = (state_q == S_CMD) && !bus.i_p3_cmd_full;
        pop      = (state_q == S_RD) && !bus.i_p3_rd_empty && !bus.i_buf_full
                   && (burst_cnt_q < burst_words);
        last_pop = pop && (burst_cnt_q == burst_words - 7'd1);
        drained  = (burst_cnt_q == burst_words);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (frame_avail_q && i_frame_en && calib_sync_q && !bus.i_buf_pf) state_d = S_REQ;
            S_REQ:  if (i_rd_ack) state_d = able_to_read ? S_CMD : S_IDLE;
            S_CMD:  if (!bus.i_p3_cmd_full) state_d = S_RD;
            // A programmable-full back FIFO parks us here after the burst drains.
            S_RD: begin
                if (last_pop || drained) begin
                    if (words_left == '0)   state_d = S_IDLE;
                    else if (!bus.i_buf_pf) state_d = S_CMD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_avail_d   = frame_avail_q;
        last_done_ptr_d = last_done_ptr_q;
        if (ack_ok)  frame_avail_d = 1'b0;
        // A write finishing in the ack cycle leaves its frame pending.
        if (wr_fall) begin
            frame_avail_d   = 1'b1;
            last_done_ptr_d = iv_wr_frame_ptr;
        end

        depth_d = depth_q;
        if (state_q == S_IDLE && (iv_frame_depth == 3'b001 || iv_frame_depth == 3'b010
                                  || iv_frame_depth == 3'b100))
            depth_d = iv_frame_depth;

        rd_req_d = (state_q == S_REQ) && !i_rd_ack;

        reading_d = reading_q;
        rd_ptr_d  = rd_ptr_q;
        if (state_q == S_IDLE) reading_d = 1'b0;
        else if (ack_ok) begin
            reading_d = 1'b1;
            rd_ptr_d  = (depth_q == 3'b001) ? 2'd0 : last_done_ptr_q;
        end

        cmd_en_d    = issue;
        burst_cnt_d = burst_cnt_q;
        if (issue)    burst_cnt_d = '0;
        else if (pop) burst_cnt_d = burst_cnt_q + 7'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            calib_meta_q    <= 1'b0;
            calib_sync_q    <= 1'b0;
            writing_q       <= 1'b0;
            frame_avail_q   <= 1'b0;
            last_done_ptr_q <= '0;
            depth_q         <= '0;
            rd_req_q        <= 1'b0;
            reading_q       <= 1'b0;
            rd_ptr_q        <= '0;
            cmd_en_q        <= 1'b0;
            burst_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            calib_meta_q    <= i_calib_done;
            calib_sync_q    <= calib_meta_q;
            writing_q       <= i_writing;
            frame_avail_q   <= frame_avail_d;
            last_done_ptr_q <= last_done_ptr_d;
            depth_q         <= depth_d;
            rd_req_q        <= rd_req_d;
            reading_q       <= reading_d;
            rd_ptr_q        <= rd_ptr_d;
            cmd_en_q        <= cmd_en_d;
            burst_cnt_q     <= burst_cnt_d;
        end
    end

    assign o_rd_req        = rd_req_q;
    assign o_reading       = reading_q;
    assign ov_rd_frame_ptr = rd_ptr_q;
    assign bus.o_p3_cmd_en = cmd_en_q;
    assign bus.o_p3_rd_en  = pop;
    assign bus.o_buf_wr_en = pop;
    assign bus.ov_buf_din  = bus.iv_p3_rd_data;

endmodule
